mem_read_initiator: RTL and testbench

- Read-request initiator on the accelerator side of the host memory path.
- Accepts a start command with a base cache-line address and a line count.
- Issues tagged line read requests toward the host memory interface and collects responses that may return out of order.
- Delivers the 512-bit lines strictly in request order to a consumer (image, program or weight loader) over a valid/ready stream.

---
 rtl/mem_read_initiator_if.sv | 37 +++
 rtl/mem_read_initiator.sv | 142 ++++++++++++++
 tb/tb_mem_read_initiator.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_initiator_if.sv
// Request, response and ordered-output channels of the memory read initiator.
// master = initiator side, slave = host memory plus consumer side.
interface mem_read_initiator_if #(
    parameter int ADDR_W = 42,
    parameter int DATA_W = 512,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output req_valid, req_addr, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_tag, rsp_data,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  req_valid, req_addr, req_tag,
        output req_ready,
        output rsp_valid, rsp_tag, rsp_data,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_read_initiator.sv
// Tagged line-read initiator with in-order reorder buffer for out-of-order responses.
// Optional response checking: define MEM_READ_INITIATOR_RSP_CHECK_EN.
module mem_read_initiator #(
    parameter int ADDR_W = 42,
    parameter int DATA_W = 512,
    parameter int TAG_W  = 4,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_lines,
    output logic              busy,
    output logic              done,
    output logic              err,
    mem_read_initiator_if.master bus
);
    localparam int DEPTH = 2**TAG_W;
    localparam logic [LEN_W:0] DEPTH_C = (LEN_W+1)'(DEPTH);
    localparam logic [LEN_W:0] ONE_C = (LEN_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  num;
    logic [LEN_W:0]    issued;
    logic [LEN_W:0]    consumed;
    logic [LEN_W:0]    outstanding;
    logic [LEN_W:0]    total;
    logic [DEPTH-1:0]  rob_vld;
    logic [DATA_W-1:0] rob_data [DEPTH];
    logic [TAG_W-1:0]  head;
    logic              req_fire;
    logic              out_fire;
    logic              rsp_wr;
    logic              rsp_bad;

    assign total       = {1'b0, num};
    assign outstanding = issued - consumed;
    assign head        = consumed[TAG_W-1:0];
    assign busy        = (state != IDLE);

    assign bus.req_valid = (state == FETCH) && (issued < total)
                         && (outstanding < DEPTH_C);
    assign bus.req_addr  = base + ADDR_W'(issued);
    assign bus.req_tag   = issued[TAG_W-1:0];

    // Gate with the line count so stray valid bits never leak out
    assign bus.out_valid = (state != IDLE) && (consumed < total)
                         && rob_vld[head];
    assign bus.out_data  = rob_data[head];
    assign bus.out_last  = bus.out_valid && (consumed == total - ONE_C);

    assign req_fire = bus.req_valid && bus.req_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

`ifdef MEM_READ_INITIATOR_RSP_CHECK_EN
    logic [TAG_W-1:0] rsp_off;
    logic             rsp_pending;

    // A tag is outstanding when its distance from the head is below the count
    assign rsp_off     = bus.rsp_tag - head;
    assign rsp_pending = (outstanding >= DEPTH_C)
                       || ((LEN_W+1)'(rsp_off) < outstanding);
    assign rsp_bad     = (state != IDLE) && bus.rsp_valid
                       && (!rsp_pending || rob_vld[bus.rsp_tag]);
`else
    assign rsp_bad = 1'b0;
`endif

    assign rsp_wr = (state != IDLE) && bus.rsp_valid && !rsp_bad;

    always_ff @(posedge clk) begin
        if (rsp_wr) begin
            rob_data[bus.rsp_tag] <= bus.rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            num      <= '0;
            issued   <= '0;
            consumed <= '0;
            rob_vld  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_fire) begin
                rob_vld[head] <= 1'b0;
            end
            if (rsp_wr) begin
                rob_vld[bus.rsp_tag] <= 1'b1;
            end
            if (rsp_bad) begin
                err <= 1'b1;
            end
            if (req_fire) begin
                issued <= issued + ONE_C;
            end
            if (out_fire) begin
                consumed <= consumed + ONE_C;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (num_lines != '0) begin
                            base     <= base_addr;
                            num      <= num_lines;
                            issued   <= '0;
                            consumed <= '0;
                            rob_vld  <= '0;
                            state    <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (out_fire && bus.out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (issued + (LEN_W+1)'(req_fire) == total) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && bus.out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_read_initiator.sv
// Directed bench for mem_read_initiator: ordering, backpressure, full ROB,
// zero-length command, address wrap, reset and optional response checking.
module tb_mem_read_initiator;
    localparam int ADDR_W = 42;
    localparam int DATA_W = 512;
    localparam int TAG_W  = 4;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_lines;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    mem_read_initiator_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)
    ) bus ();

    mem_read_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] line(input int k);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(k);
        return {16{w}};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requests always accepted; each response returns the cycle after its request
    task automatic run_inorder(input logic [ADDR_W-1:0] b, input int n,
                               input bit tog, input string id,
                               output logic [ADDR_W-1:0] addr2);
        int nreq = 0;
        int nout = 0;
        bit fired = 0;
        int fidx = 0;
        bit held = 0;
        logic [DATA_W-1:0] hd = '0;
        logic [ADDR_W-1:0] ea;
        addr2 = '1;
        base_addr = b;
        num_lines = LEN_W'(n);
        start = 1'b1;
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        chk({id, "_busy"}, busy, 1'b1);
        for (int c = 0; c < 100 && nout < n; c++) begin
            bus.rsp_valid = fired;
            bus.rsp_tag   = TAG_W'(fidx);
            bus.rsp_data  = line(fidx);
            fired = 0;
            if (tog) bus.out_ready = c[0];
            if (held) begin
                chk({id, "_hold_v"}, bus.out_valid, 1'b1);
                chk({id, "_hold_d"}, bus.out_data, hd);
            end
            held = 0;
            if (bus.req_valid) begin
                ea = b + ADDR_W'(nreq);
                chk({id, "_addr"}, bus.req_addr, ea);
                chk({id, "_tag"}, bus.req_tag, TAG_W'(nreq));
                if (nreq == 2) addr2 = bus.req_addr;
                fired = 1;
                fidx = nreq;
                nreq++;
            end
            if (bus.out_valid) begin
                chk({id, "_data"}, bus.out_data, line(nout));
                chk({id, "_last"}, bus.out_last, (nout == n - 1));
                if (bus.out_ready) nout++;
                else begin
                    held = 1;
                    hd = bus.out_data;
                end
            end
            step();
        end
        bus.rsp_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk({id, "_nout"}, 32'(nout), 32'(n));
        chk({id, "_nreq"}, 32'(nreq), 32'(n));
        chk({id, "_done"}, done, 1'b1);
        chk({id, "_idle"}, busy, 1'b0);
        step();
        chk({id, "_done_off"}, done, 1'b0);
    endtask

    initial begin
        int nreq;
        logic [ADDR_W-1:0] a2;
        logic [ADDR_W-1:0] b2;

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_lines = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_tag = '0;
        bus.rsp_data = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req_valid", bus.req_valid, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        step();

        // Four lines, in-order responses, consumer always ready
        run_inorder(42'h100, 4, 1'b0, "t1", a2);

        // Twenty lines with responses withheld: ROB fills at 16
        b2 = 42'h2000;
        base_addr = b2;
        num_lines = 16'd20;
        start = 1'b1;
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        nreq = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.req_valid) begin
                chk("t2_addr", bus.req_addr, b2 + ADDR_W'(nreq));
                nreq++;
            end
            chk("t2_no_out", bus.out_valid, 1'b0);
            step();
        end
        chk("t2_nreq", 32'(nreq), 32'd16);
        chk("t2_full", bus.req_valid, 1'b0);
        bus.rsp_valid = 1'b1;
        bus.rsp_tag = 4'd0;
        bus.rsp_data = line(0);
        step();
        bus.rsp_valid = 1'b0;
        chk("t2_out_v", bus.out_valid, 1'b1);
        chk("t2_out_d", bus.out_data, line(0));
        chk("t2_still_full", bus.req_valid, 1'b0);
        step();
        chk("t2_req17_v", bus.req_valid, 1'b1);
        chk("t2_req17_a", bus.req_addr, 42'h2010);
        chk("t2_req17_t", bus.req_tag, 4'd0);

        // Reset mid-FETCH, then a stale response while idle
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_tag = 4'd1;
        bus.rsp_data = line(1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_req_v", bus.req_valid, 1'b0);
        chk("t6_out_v", bus.out_valid, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_err", err, 1'b0);
        step();
        bus.rsp_valid = 1'b0;
        chk("t6_stale_out", bus.out_valid, 1'b0);
        chk("t6_stale_last", bus.out_last, 1'b0);
        step();

        // Out-of-order responses 3,1,0,2
        base_addr = 42'h300;
        num_lines = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_req_v", bus.req_valid, 1'b1);
            step();
        end
        chk("t3_req_end", bus.req_valid, 1'b0);
        bus.rsp_valid = 1'b1;
        bus.rsp_tag = 4'd3;
        bus.rsp_data = line(3);
        chk("t3_wait0", bus.out_valid, 1'b0);
        step();
        bus.rsp_tag = 4'd1;
        bus.rsp_data = line(1);
        chk("t3_wait1", bus.out_valid, 1'b0);
        step();
        bus.rsp_tag = 4'd0;
        bus.rsp_data = line(0);
        chk("t3_wait2", bus.out_valid, 1'b0);
        step();
        bus.rsp_tag = 4'd2;
        bus.rsp_data = line(2);
        chk("t3_v0", bus.out_valid, 1'b1);
        chk("t3_d0", bus.out_data, line(0));
        step();
        bus.rsp_valid = 1'b0;
        chk("t3_v1", bus.out_valid, 1'b1);
        chk("t3_d1", bus.out_data, line(1));
        step();
        chk("t3_d2", bus.out_data, line(2));
        chk("t3_l2", bus.out_last, 1'b0);
        step();
        chk("t3_d3", bus.out_data, line(3));
        chk("t3_l3", bus.out_last, 1'b1);
        step();
        chk("t3_done", done, 1'b1);
        chk("t3_idle", busy, 1'b0);
        step();

        // Zero-length command
        num_lines = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_busy", busy, 1'b0);
        chk("t4_req_v", bus.req_valid, 1'b0);
        chk("t4_done", done, 1'b1);
        step();
        chk("t4_done_off", done, 1'b0);
        chk("t4_busy2", busy, 1'b0);

        // Consumer toggling ready, address wraps at the top of the space
        run_inorder(42'h3FF_FFFF_FFFE, 8, 1'b1, "t5", a2);
        chk("t5_wrap", a2, 42'h0);

        // Duplicate response during FETCH
        base_addr = 42'h500;
        num_lines = 16'd4;
        start = 1'b1;
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_tag = 4'd0;
        bus.rsp_data = line(0);
        step();
        bus.rsp_data = line(9);
        step();
        bus.rsp_tag = 4'd1;
        bus.rsp_data = line(1);
        bus.out_ready = 1'b1;
`ifdef MEM_READ_INITIATOR_RSP_CHECK_EN
        chk("t7_err_set", err, 1'b1);
        chk("t7_keep", bus.out_data, line(0));
`else
        chk("t7_err_tied", err, 1'b0);
        chk("t7_overwrite", bus.out_data, line(9));
`endif
        step();
        bus.rsp_tag = 4'd2;
        bus.rsp_data = line(2);
        step();
        bus.rsp_tag = 4'd3;
        bus.rsp_data = line(3);
        step();
        bus.rsp_valid = 1'b0;
        for (int c = 0; c < 20 && !done; c++) step();
        chk("t7_done", done, 1'b1);
`ifdef MEM_READ_INITIATOR_RSP_CHECK_EN
        chk("t7_err_sticky", err, 1'b1);
`endif
        num_lines = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t7_err_clr", err, 1'b0);
        chk("t7_done0", done, 1'b1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
